instruction_decode_hz: RTL and testbench
========================================

# instruction_decode_hz

Parametrised DLX instruction-decode stage with hazard handling. It sits between the fetch stage and the execute stage and contains:
- its own register file, with write-back bypass;
- the field decoder and immediate extension;
- load-use hazard detection with a fetch stall;
- an ID/EX pipeline register that supports hold and flush.

All execute-facing outputs are registered, with a valid bit qualifying them.

## Interface
- DATA_WIDTH, 32, register/operand width (≥ IMEDIATE_WIDTH)
- INSTRUCTION_WIDTH, 32, instruction width
- PC_WIDTH, 20, PC width
- REG_ADDR_WIDTH, 5, register address width; register file has 2**REG_ADDR_WIDTH entries
- OPCODE_WIDTH, 6, opcode field width
- FUNCTION_WIDTH, 6, function field width
- IMEDIATE_WIDTH, 16, immediate field width
- PC_OFFSET_WIDTH, 26, jump offset field width
- ZERO_EXT_LOGIC, 1, when 1, ANDI/ORI/XORI immediates are zero-extended; when 0, all immediates are sign-extended
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instruction_in  in  INSTRUCTION_WIDTH  instruction from fetch
- inst_valid_in  in  1  instruction_in is valid
- new_pc_in  in  PC_WIDTH  PC+4 of instruction_in
- wb_write_enable  in  1  write-back strobe
- wb_reg_wr_addr  in  REG_ADDR_WIDTH  write-back register
- wb_write_data  in  DATA_WIDTH  write-back data
- hold_in  in  1  execute cannot accept; freeze ID/EX
- flush_in  in  1  squash the instruction in decode (taken branch/jump)
- stall_out  out  1  fetch must hold instruction_in/new_pc_in stable
- valid_out  out  1  ID/EX contents valid
- opcode_out, inst_function_out, read_address1_out, read_address2_out, reg_wr_addr_out  out  field widths  registered decode fields
- data_alu_a_out, data_alu_b_out, constant_out  out  DATA_WIDTH  operands and extended immediate
- new_pc_out  out  PC_WIDTH; pc_offset_out  out  PC_OFFSET_WIDTH
- reg_wr_en_out, imm_inst_out, mem_data_rd_en_out, mem_data_wr_en_out, write_back_mux_sel_out, branch_inst_out, jump_inst_out, jump_use_r_out  out  1  control

## Operation
- Fields (32-bit layout):
  - opcode = [31:26], rs1 = [25:21], rs2 = [20:16], R-type rd = [15:11], function = [5:0], imm = [15:0], offset = [25:0].
- Classes:
  - **R-type (op 0x00):** reads rs1 and rs2, writes rd.
  - **Load (op[5:3] = 100):** reads rs1; asserts mem_rd and wb_sel; imm; writes [20:16].
  - **Store (op[5:3] = 101):** reads rs1 and rs2; asserts mem_wr; imm; no write.
  - **BEQZ/BNEZ (0x04/0x05):** reads rs1; asserts branch; imm; no write.
  - **J (0x02):** asserts jump; no reads; no write.
  - **JAL (0x03):** asserts jump; writes the link register (all-ones address).
  - **JR (0x12):** asserts jump and jump_use_r; reads rs1.
  - **JALR (0x13):** asserts jump and jump_use_r; reads rs1; writes the link register.
  - **All other opcodes:** immediate ALU; reads rs1; imm; writes [20:16].
- reg_wr_en is forced to 0 when the destination register is 0.
- Register file:
  - Written on the rising edge when wb_write_enable = 1 and wb_reg_wr_addr ≠ 0.
  - Register 0 always reads 0.
  - Same-cycle bypass: a read address equal to a nonzero wb_reg_wr_addr with wb_write_enable = 1 returns wb_write_data.
- Load-use hazard:
  - hazard = valid_out & mem_data_rd_en_out & reg_wr_en_out & (reg_wr_addr_out matches a source register the current instruction reads) & inst_valid_in.
- Per-cycle priority: flush_in > hold_in > hazard > normal.
  - **flush_in:** ID/EX loads a bubble; stall_out = 0.
  - **hold_in:** ID/EX keeps its value; stall_out = 1.
  - **hazard:** ID/EX loads a bubble; stall_out = 1.
  - **normal:** ID/EX loads the decoded instruction; valid_out ← inst_valid_in; stall_out = 0.
- Bubble: valid_out = 0 and all control outputs 0. Data and field outputs are don't-care; the implementation drives them to 0.
- An instruction with inst_valid_in = 0 is loaded as a bubble.
- Extension: constant_out = imm sign-extended to DATA_WIDTH. When ZERO_EXT_LOGIC = 1 and opcode ∈ {0x0C, 0x0D, 0x0E}, it is zero-extended instead.

## Timing
- Decode latency: 1 cycle, instruction_in edge N → outputs after edge N.
- stall_out is combinational from the current inputs and ID/EX state.
- Load-use costs exactly one bubble. On the next cycle ID/EX holds the bubble, so the hazard clears.
- Reset (asynchronous, rst_n = 0): all outputs 0, valid_out = 0, stall_out = 0, all registers 0. Deassertion takes effect at the next rising edge.
- A reset asserted mid-stall clears the stall immediately.
- A write-back in the same cycle as decode is visible through the bypass, with no extra latency.

## Test plan
- **Bypass:** wb writes r3 = 0x0000_00AA while decoding ADD r5, r3, r0 (R-type) → next cycle data_alu_a_out = 0xAA, valid_out = 1, reg_wr_addr_out = 5.
- **Load-use:** LW r2, 4(r1), then ADD r4, r2, r2 →
  - stall_out = 1 for exactly one cycle;
  - one bubble (valid_out = 0);
  - ADD issues the following cycle.
  - Repeat with the load targeting r0 → no stall.
- **Immediates:**
  - ORI with imm 0x8001 → constant_out = 0x0000_8001 (ZERO_EXT_LOGIC = 1) or 0xFFFF_8001 (ZERO_EXT_LOGIC = 0).
  - ADDI with imm 0x8001 → 0xFFFF_8001 for either setting.
- **Jumps:**
  - JAL → reg_wr_addr_out = 31, jump_inst_out = 1, jump_use_r_out = 0.
  - JR r7 → jump_use_r_out = 1, read_address1_out = 7.
  - J with offset 0x3FF_FFFF → pc_offset_out = 0x3FF_FFFF.
- **Hold/flush:**
  - hold_in for 3 cycles → outputs frozen; stall_out = 1 throughout.
  - flush_in together with hold_in and a hazard → bubble next cycle; stall_out = 0.
- **Reset:** assert rst_n = 0 mid-stream, asynchronously between edges → all outputs 0 immediately. After release, reading r3 returns 0.

Source files
------------

// File: rtl/instruction_decode_hz.sv
// instruction_decode_hz: DLX decode stage with register file, write-back bypass,
// load-use stall detection and a holdable/flushable ID/EX register.
module instruction_decode_hz #(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 20,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int IMEDIATE_WIDTH    = 16,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter bit ZERO_EXT_LOGIC    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         inst_valid_in,
  input  logic [PC_WIDTH-1:0]          new_pc_in,
  input  logic                         wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]        wb_write_data,
  input  logic                         hold_in,
  input  logic                         flush_in,
  output logic                         stall_out,
  output logic                         valid_out,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]        data_alu_a_out,
  output logic [DATA_WIDTH-1:0]        data_alu_b_out,
  output logic [DATA_WIDTH-1:0]        constant_out,
  output logic [PC_WIDTH-1:0]          new_pc_out,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset_out,
  output logic                         reg_wr_en_out,
  output logic                         imm_inst_out,
  output logic                         mem_data_rd_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic                         jump_use_r_out
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int OW = OPCODE_WIDTH;
  localparam int RW = REG_ADDR_WIDTH;

  localparam logic [OW-1:0] OP_RTYPE = OW'(6'h00);
  localparam logic [OW-1:0] OP_J     = OW'(6'h02);
  localparam logic [OW-1:0] OP_JAL   = OW'(6'h03);
  localparam logic [OW-1:0] OP_BEQZ  = OW'(6'h04);
  localparam logic [OW-1:0] OP_BNEZ  = OW'(6'h05);
  localparam logic [OW-1:0] OP_ANDI  = OW'(6'h0C);
  localparam logic [OW-1:0] OP_ORI   = OW'(6'h0D);
  localparam logic [OW-1:0] OP_XORI  = OW'(6'h0E);
  localparam logic [OW-1:0] OP_JR    = OW'(6'h12);
  localparam logic [OW-1:0] OP_JALR  = OW'(6'h13);

  typedef struct packed {
    logic                       valid;
    logic [OW-1:0]              opcode;
    logic [FUNCTION_WIDTH-1:0]  funct;
    logic [RW-1:0]              ra1;
    logic [RW-1:0]              ra2;
    logic [RW-1:0]              wa;
    logic [DATA_WIDTH-1:0]      a;
    logic [DATA_WIDTH-1:0]      b;
    logic [DATA_WIDTH-1:0]      k;
    logic [PC_WIDTH-1:0]        pc;
    logic [PC_OFFSET_WIDTH-1:0] off;
    logic                       reg_wr_en;
    logic                       imm;
    logic                       mem_rd;
    logic                       mem_wr;
    logic                       wb_sel;
    logic                       branch;
    logic                       jump;
    logic                       jump_r;
  } idex_t;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  idex_t                 idex_q, idex_d, dec;

  logic [OW-1:0]             opc;
  logic [RW-1:0]             rs1, rs2, rd;
  logic [IMEDIATE_WIDTH-1:0] imm;
  logic                      uses_rs1, uses_rs2, writes;
  logic                      hazard;

  assign opc = instruction_in[IW-1 -: OW];
  assign rs1 = instruction_in[IW-OW-1 -: RW];
  assign rs2 = instruction_in[IW-OW-RW-1 -: RW];
  assign rd  = instruction_in[IW-OW-2*RW-1 -: RW];
  assign imm = instruction_in[IMEDIATE_WIDTH-1:0];

  always_comb begin
    regs_d = regs_q;
    if (wb_write_enable && (wb_reg_wr_addr != '0))
      regs_d[wb_reg_wr_addr] = wb_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    dec.valid  = 1'b1;
    dec.opcode = opc;
    dec.funct  = instruction_in[FUNCTION_WIDTH-1:0];
    dec.pc     = new_pc_in;
    dec.off    = instruction_in[PC_OFFSET_WIDTH-1:0];
    dec.k      = DATA_WIDTH'($signed(imm));
    dec.wa     = rs2;

    if (opc == OP_RTYPE) begin
      uses_rs2 = 1'b1;
      writes   = 1'b1;
      dec.wa   = rd;
    end else if (opc[OW-1 -: 3] == 3'b100) begin
      dec.mem_rd = 1'b1;
      dec.wb_sel = 1'b1;
      dec.imm    = 1'b1;
      writes     = 1'b1;
    end else if (opc[OW-1 -: 3] == 3'b101) begin
      uses_rs2   = 1'b1;
      dec.mem_wr = 1'b1;
      dec.imm    = 1'b1;
    end else if (opc == OP_BEQZ || opc == OP_BNEZ) begin
      dec.branch = 1'b1;
      dec.imm    = 1'b1;
    end else if (opc == OP_J || opc == OP_JAL) begin
      uses_rs1 = 1'b0;
      dec.jump = 1'b1;
      writes   = (opc == OP_JAL);
      dec.wa   = '1;
    end else if (opc == OP_JR || opc == OP_JALR) begin
      dec.jump   = 1'b1;
      dec.jump_r = 1'b1;
      writes     = (opc == OP_JALR);
      dec.wa     = '1;
    end else begin
      dec.imm = 1'b1;
      writes  = 1'b1;
      if (ZERO_EXT_LOGIC && (opc == OP_ANDI || opc == OP_ORI || opc == OP_XORI))
        dec.k = DATA_WIDTH'(imm);
    end

    if (!writes) dec.wa = '0;
    dec.reg_wr_en = writes && (dec.wa != '0);
    dec.ra1 = uses_rs1 ? rs1 : '0;
    dec.ra2 = uses_rs2 ? rs2 : '0;

    // regs_d already folds in the same-cycle write-back, giving the bypass
    dec.a = regs_d[rs1];
    dec.b = regs_d[rs2];
  end

  assign hazard = idex_q.valid && idex_q.mem_rd && idex_q.reg_wr_en && inst_valid_in &&
                  ((uses_rs1 && rs1 == idex_q.wa) || (uses_rs2 && rs2 == idex_q.wa));

  always_comb begin
    idex_d    = '0;
    stall_out = 1'b0;
    if (flush_in) begin
      idex_d = '0;
    end else if (hold_in) begin
      idex_d    = idex_q;
      stall_out = 1'b1;
    end else if (hazard) begin
      stall_out = 1'b1;
    end else if (inst_valid_in) begin
      idex_d = dec;
    end
    if (!rst_n) stall_out = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign valid_out              = idex_q.valid;
  assign opcode_out             = idex_q.opcode;
  assign inst_function_out      = idex_q.funct;
  assign read_address1_out      = idex_q.ra1;
  assign read_address2_out      = idex_q.ra2;
  assign reg_wr_addr_out        = idex_q.wa;
  assign data_alu_a_out         = idex_q.a;
  assign data_alu_b_out         = idex_q.b;
  assign constant_out           = idex_q.k;
  assign new_pc_out             = idex_q.pc;
  assign pc_offset_out          = idex_q.off;
  assign reg_wr_en_out          = idex_q.reg_wr_en;
  assign imm_inst_out           = idex_q.imm;
  assign mem_data_rd_en_out     = idex_q.mem_rd;
  assign mem_data_wr_en_out     = idex_q.mem_wr;
  assign write_back_mux_sel_out = idex_q.wb_sel;
  assign branch_inst_out        = idex_q.branch;
  assign jump_inst_out          = idex_q.jump;
  assign jump_use_r_out         = idex_q.jump_r;

endmodule

// File: tb/tb_instruction_decode_hz.sv
module tb_instruction_decode_hz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_in;
  logic        inst_valid_in;
  logic [19:0] new_pc_in;
  logic        wb_write_enable;
  logic [4:0]  wb_reg_wr_addr;
  logic [31:0] wb_write_data;
  logic        hold_in, flush_in;
  logic        stall_out, valid_out;
  logic [5:0]  opcode_out, inst_function_out;
  logic [4:0]  read_address1_out, read_address2_out, reg_wr_addr_out;
  logic [31:0] data_alu_a_out, data_alu_b_out, constant_out;
  logic [19:0] new_pc_out;
  logic [25:0] pc_offset_out;
  logic        reg_wr_en_out, imm_inst_out, mem_data_rd_en_out, mem_data_wr_en_out;
  logic        write_back_mux_sel_out, branch_inst_out, jump_inst_out, jump_use_r_out;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  instruction_decode_hz #(.ZERO_EXT_LOGIC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction_in(instruction_in), .inst_valid_in(inst_valid_in), .new_pc_in(new_pc_in),
    .wb_write_enable(wb_write_enable), .wb_reg_wr_addr(wb_reg_wr_addr), .wb_write_data(wb_write_data),
    .hold_in(hold_in), .flush_in(flush_in),
    .stall_out(stall_out), .valid_out(valid_out),
    .opcode_out(opcode_out), .inst_function_out(inst_function_out),
    .read_address1_out(read_address1_out), .read_address2_out(read_address2_out),
    .reg_wr_addr_out(reg_wr_addr_out),
    .data_alu_a_out(data_alu_a_out), .data_alu_b_out(data_alu_b_out), .constant_out(constant_out),
    .new_pc_out(new_pc_out), .pc_offset_out(pc_offset_out),
    .reg_wr_en_out(reg_wr_en_out), .imm_inst_out(imm_inst_out),
    .mem_data_rd_en_out(mem_data_rd_en_out), .mem_data_wr_en_out(mem_data_wr_en_out),
    .write_back_mux_sel_out(write_back_mux_sel_out), .branch_inst_out(branch_inst_out),
    .jump_inst_out(jump_inst_out), .jump_use_r_out(jump_use_r_out)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s1, s2, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s1,
                                        input logic [4:0] d, input logic [15:0] im);
    return {op, s1, d, im};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic vld);
    @(negedge clk);
    instruction_in = ins;
    inst_valid_in  = vld;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instruction_in = '0; inst_valid_in = 1'b0; new_pc_in = '0;
    wb_write_enable = 1'b0; wb_reg_wr_addr = '0; wb_write_data = '0;
    hold_in = 1'b0; flush_in = 1'b0;
    #2;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_out); else pass_cnt++;
    total_cnt++;
    if ({constant_out, data_alu_a_out, reg_wr_en_out, jump_inst_out} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {constant_out, data_alu_a_out});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    drive(enc_r(5'd3, 5'd0, 5'd5, 6'h20), 1'b1);
    new_pc_in = 20'h00104;
    wb_write_enable = 1'b1; wb_reg_wr_addr = 5'd3; wb_write_data = 32'h0000_00AA;
    edge_sample();
    wb_write_enable = 1'b0;
    total_cnt++;
    if (data_alu_a_out !== 32'hAA) $display("FAIL bypass_a: got %h expected 000000aa", data_alu_a_out); else pass_cnt++;
    total_cnt++;
    if (valid_out !== 1'b1) $display("FAIL bypass_valid: got %b expected 1", valid_out); else pass_cnt++;
    total_cnt++;
    if (reg_wr_addr_out !== 5'd5 || reg_wr_en_out !== 1'b1)
      $display("FAIL bypass_dest: got %0d/%b expected 5/1", reg_wr_addr_out, reg_wr_en_out);
    else pass_cnt++;
    total_cnt++;
    if (new_pc_out !== 20'h00104 || inst_function_out !== 6'h20)
      $display("FAIL bypass_pc_fn: got %h/%h expected 00104/20", new_pc_out, inst_function_out);
    else pass_cnt++;
    drive(enc_r(5'd3, 5'd0, 5'd6, 6'h20), 1'b1);
    edge_sample();
    total_cnt++;
    if (data_alu_a_out !== 32'hAA) $display("FAIL regfile_read: got %h expected 000000aa", data_alu_a_out); else pass_cnt++;
  endtask

  task automatic test_load_use();
    drive(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 1'b1);
    edge_sample();
    total_cnt++;
    if ({mem_data_rd_en_out, write_back_mux_sel_out, imm_inst_out, reg_wr_addr_out, constant_out} !== {3'b111, 5'd2, 32'd4})
      $display("FAIL load_decode: got %b%b%b/%0d/%h expected 111/2/4", mem_data_rd_en_out,
               write_back_mux_sel_out, imm_inst_out, reg_wr_addr_out, constant_out);
    else pass_cnt++;
    drive(enc_r(5'd2, 5'd2, 5'd4, 6'h20), 1'b1);
    #1;
    total_cnt++;
    if (stall_out !== 1'b1) $display("FAIL load_use_stall: got %b expected 1", stall_out); else pass_cnt++;
    edge_sample();
    total_cnt++;
    if (valid_out !== 1'b0 || reg_wr_en_out !== 1'b0)
      $display("FAIL load_use_bubble: got %b/%b expected 0/0", valid_out, reg_wr_en_out);
    else pass_cnt++;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL load_use_stall_clear: got %b expected 0", stall_out); else pass_cnt++;
    edge_sample();
    total_cnt++;
    if (valid_out !== 1'b1 || reg_wr_addr_out !== 5'd4)
      $display("FAIL load_use_issue: got %b/%0d expected 1/4", valid_out, reg_wr_addr_out);
    else pass_cnt++;
    drive(enc_i(6'h23, 5'd1, 5'd0, 16'h0004), 1'b1);
    edge_sample();
    drive(enc_r(5'd0, 5'd0, 5'd4, 6'h20), 1'b1);
    #1;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL load_r0_stall: got %b expected 0", stall_out); else pass_cnt++;
    edge_sample();
    total_cnt++;
    if (valid_out !== 1'b1 || reg_wr_addr_out !== 5'd4)
      $display("FAIL load_r0_issue: got %b/%0d expected 1/4", valid_out, reg_wr_addr_out);
    else pass_cnt++;
  endtask

  task automatic test_immediates();
    drive(enc_i(6'h0D, 5'd0, 5'd9, 16'h8001), 1'b1);
    edge_sample();
    total_cnt++;
    if (constant_out !== 32'h0000_8001) $display("FAIL ori_zext: got %h expected 00008001", constant_out); else pass_cnt++;
    drive(enc_i(6'h08, 5'd0, 5'd9, 16'h8001), 1'b1);
    edge_sample();
    total_cnt++;
    if (constant_out !== 32'hFFFF_8001) $display("FAIL addi_sext: got %h expected ffff8001", constant_out); else pass_cnt++;
  endtask

  task automatic test_jumps();
    drive({6'h03, 26'h0000040}, 1'b1);
    edge_sample();
    total_cnt++;
    if ({reg_wr_addr_out, jump_inst_out, jump_use_r_out, reg_wr_en_out} !== {5'd31, 3'b101})
      $display("FAIL jal: got %0d/%b/%b/%b expected 31/1/0/1", reg_wr_addr_out, jump_inst_out,
               jump_use_r_out, reg_wr_en_out);
    else pass_cnt++;
    drive(enc_i(6'h12, 5'd7, 5'd0, 16'h0000), 1'b1);
    edge_sample();
    total_cnt++;
    if ({jump_use_r_out, jump_inst_out, read_address1_out, reg_wr_en_out} !== {2'b11, 5'd7, 1'b0})
      $display("FAIL jr: got %b/%b/%0d/%b expected 1/1/7/0", jump_use_r_out, jump_inst_out,
               read_address1_out, reg_wr_en_out);
    else pass_cnt++;
    drive({6'h02, 26'h3FF_FFFF}, 1'b1);
    edge_sample();
    total_cnt++;
    if (pc_offset_out !== 26'h3FF_FFFF || jump_use_r_out !== 1'b0 || reg_wr_en_out !== 1'b0)
      $display("FAIL j_offset: got %h/%b/%b expected 3ffffff/0/0", pc_offset_out, jump_use_r_out, reg_wr_en_out);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    drive(enc_i(6'h0D, 5'd0, 5'd9, 16'h8001), 1'b1);
    edge_sample();
    for (int i = 0; i < 3; i++) begin
      drive(enc_i(6'h08, 5'd0, 5'd10, 16'h1234), 1'b1);
      hold_in = 1'b1;
      #1;
      total_cnt++;
      if (stall_out !== 1'b1) $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall_out); else pass_cnt++;
      edge_sample();
      total_cnt++;
      if (constant_out !== 32'h8001 || reg_wr_addr_out !== 5'd9 || valid_out !== 1'b1)
        $display("FAIL hold_frozen[%0d]: got %h/%0d/%b expected 00008001/9/1", i, constant_out,
                 reg_wr_addr_out, valid_out);
      else pass_cnt++;
    end
    @(negedge clk);
    hold_in = 1'b0;
    edge_sample();
    total_cnt++;
    if (constant_out !== 32'h1234 || reg_wr_addr_out !== 5'd10)
      $display("FAIL hold_release: got %h/%0d expected 00001234/10", constant_out, reg_wr_addr_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 1'b1);
    edge_sample();
    drive(enc_r(5'd2, 5'd2, 5'd4, 6'h20), 1'b1);
    hold_in = 1'b1; flush_in = 1'b1;
    #1;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_out); else pass_cnt++;
    edge_sample();
    total_cnt++;
    if (valid_out !== 1'b0 || mem_data_rd_en_out !== 1'b0 || reg_wr_en_out !== 1'b0)
      $display("FAIL flush_bubble: got %b/%b/%b expected 0/0/0", valid_out, mem_data_rd_en_out, reg_wr_en_out);
    else pass_cnt++;
    @(negedge clk);
    hold_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic test_invalid();
    drive(enc_r(5'd1, 5'd1, 5'd7, 6'h20), 1'b0);
    edge_sample();
    total_cnt++;
    if (valid_out !== 1'b0 || reg_wr_en_out !== 1'b0)
      $display("FAIL invalid_bubble: got %b/%b expected 0/0", valid_out, reg_wr_en_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 1'b1);
    edge_sample();
    drive(enc_r(5'd2, 5'd2, 5'd4, 6'h20), 1'b1);
    #1;
    total_cnt++;
    if (stall_out !== 1'b1) $display("FAIL mid_reset_prestall: got %b expected 1", stall_out); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (stall_out !== 1'b0 || valid_out !== 1'b0 || mem_data_rd_en_out !== 1'b0 || reg_wr_addr_out !== 5'd0)
      $display("FAIL mid_reset_clear: got %b/%b/%b/%0d expected 0/0/0/0", stall_out, valid_out,
               mem_data_rd_en_out, reg_wr_addr_out);
    else pass_cnt++;
    drive(enc_r(5'd3, 5'd0, 5'd5, 6'h20), 1'b1);
    rst_n = 1'b1;
    edge_sample();
    total_cnt++;
    if (data_alu_a_out !== 32'h0 || valid_out !== 1'b1)
      $display("FAIL mid_reset_r3: got %h/%b expected 00000000/1", data_alu_a_out, valid_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_immediates();
    test_jumps();
    test_hold();
    test_flush();
    test_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
